al_accel_quant_ctrl: RTL and testbench

- Sequences a stream of 32-bit accumulator results through one al_accel_quant_unit instance.
- Per element, selects the per-channel multiplier and right-shift from a small config table.
- Uses the unit's enb as a pipeline clock-enable, tracking in-flight valids across the unit's fixed latency.
- Packs the int8 results four per 32-bit word onto a valid/ready output stream toward the accelerator write-back path.

---
 rtl/al_accel_pkg.sv | 21 ++
 rtl/al_accel_quant_pack.sv | 70 +++++++
 rtl/al_accel_quant_ctrl.sv | 159 +++++++++++++++
 tb/tb_al_accel_quant_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/al_accel_pkg.sv
// Shared types for the accumulator quantization controller.
//   QUANT_LAT_DEF : default pipeline depth of al_accel_quant_unit (enb cycles)
//   cfg_entry_t   : one per-channel table entry (multiplier + right shift)
//   ctrl_state_t  : controller FSM states
package al_accel_pkg;

  localparam int QUANT_LAT_DEF = 3;

  typedef struct packed {
    logic [31:0] muler;
    logic [4:0]  rshift;
  } cfg_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } ctrl_state_t;

endpackage

// File: rtl/al_accel_quant_pack.sv
// Byte packer and output register for quantized int8 results.
//   clk, resetn         : clock, async active-low reset
//   clr                 : job start; drops any partial word
//   in_valid/in_data    : one int8 result (only pulsed when the pipeline advances)
//   in_last             : in_data is the final element of the job (forces a flush)
//   out_valid/out_ready : packed word handshake; out_data byte0 = earliest element
//   out_last            : high with the final word of the job
//   pending             : a partial word is being assembled
module al_accel_quant_pack (
  input  logic        clk,
  input  logic        resetn,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        pending
);

  logic [1:0]  pos;
  logic [31:0] word_q;
  logic [31:0] word_nxt;
  logic        flush;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    word_nxt = word_q;
    word_nxt[{pos, 3'b000} +: 8] = in_data;
  end

  // A word leaves either when its fourth byte lands or when the job's last
  // element arrives; bytes above pos are still zero from the previous clear.
  assign flush   = in_valid & ((pos == 2'd3) | in_last);
  assign pending = (pos != 2'd0);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pos       <= 2'd0;
      word_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (clr || flush) begin
        pos    <= 2'd0;
        word_q <= '0;
      end else if (in_valid) begin
        pos    <= pos + 2'd1;
        word_q <= word_nxt;
      end

      // in_valid only fires when the upstream pipeline is not stalled, so the
      // output register is either empty or being accepted this cycle.
      if (flush) begin
        out_valid <= 1'b1;
        out_data  <= word_nxt;
        out_last  <= in_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/al_accel_quant_ctrl.sv
// Sequences 32-bit accumulator results through an external al_accel_quant_unit
// and packs the int8 results four per word onto a valid/ready stream.
//   clk, resetn                    : clock, async active-low reset
//   cfg_we/addr/muler/rshift       : per-channel table write (IDLE only)
//   start, num_ch, len             : job start pulse and job parameters
//   busy, done                     : job status; done pulses once per job
//   acc_valid/acc_ready/acc_data   : input element stream
//   quant_di/muler/rshift/enb/do   : quant unit interface; enb is its clock enable
//   out_valid/out_ready/out_data/out_last : packed output stream
module al_accel_quant_ctrl
  import al_accel_pkg::*;
#(
  parameter int QUANT_LAT = QUANT_LAT_DEF,
  parameter int CH_W      = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_addr,
  input  logic [31:0]      cfg_muler,
  input  logic [4:0]       cfg_rshift,
  input  logic             start,
  input  logic [CH_W:0]    num_ch,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  output logic             done,
  input  logic             acc_valid,
  output logic             acc_ready,
  input  logic [31:0]      acc_data,
  output logic [31:0]      quant_di,
  output logic [31:0]      quant_muler,
  output logic [4:0]       quant_rshift,
  output logic             quant_enb,
  input  logic [7:0]       quant_do,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last
);

  ctrl_state_t     state, state_nxt;
  cfg_entry_t      cfg_tbl [2**CH_W];

  logic [CNT_W-1:0] len_q, issued, rcv_cnt;
  logic [CH_W:0]    num_ch_q;
  logic [CH_W-1:0]  ch;
  logic [QUANT_LAT-1:0] vpipe;
  logic [31:0]      di_q, muler_q;
  logic [4:0]       rshift_q;

  logic stall, hs, start_ok, consume, last_elem, pk_pending;

  // NOTE: the table is plain storage with no reset; software reprograms it.
  always_ff @(posedge clk) begin
    if (cfg_we && state == IDLE) begin
      cfg_tbl[cfg_addr] <= '{muler: cfg_muler, rshift: cfg_rshift};
    end
  end

  assign stall    = out_valid & ~out_ready;
  assign hs       = acc_valid & acc_ready;
  assign start_ok = (state == IDLE) & start;
  assign busy     = (state == RUN) | (state == DRAIN);
  assign done     = (state == DONE);

  // A 1 at the tail of the valid pipe marks quant_do as a real result; it is
  // consumed only on an advancing cycle so a stalled result is seen once.
  assign consume   = quant_enb & vpipe[QUANT_LAT-1];
  assign last_elem = (rcv_cnt == len_q - 1'b1);

  always_comb begin
    state_nxt = state;
    quant_enb = 1'b0;
    acc_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = (len == '0) ? DONE : RUN;
      end
      RUN: begin
        quant_enb = ~stall;
        acc_ready = ~stall & (issued < len_q);
        if (issued == len_q) state_nxt = DRAIN;
      end
      DRAIN: begin
        quant_enb = ~stall;
        if (vpipe == '0 && !pk_pending && !out_valid) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      len_q    <= '0;
      num_ch_q <= '0;
      issued   <= '0;
      ch       <= '0;
      rcv_cnt  <= '0;
      vpipe    <= '0;
    end else if (start_ok) begin
      len_q    <= len;
      num_ch_q <= (num_ch == '0) ? (CH_W+1)'(1) : num_ch;
      issued   <= '0;
      ch       <= '0;
      rcv_cnt  <= '0;
      vpipe    <= '0;
    end else begin
      if (hs) begin
        issued <= issued + 1'b1;
        ch     <= ({1'b0, ch} == num_ch_q - 1'b1) ? '0 : ch + 1'b1;
      end
      if (consume) rcv_cnt <= rcv_cnt + 1'b1;
      if (quant_enb) vpipe <= (vpipe << 1) | QUANT_LAT'(hs);
    end
  end

  // The quant unit samples its inputs on the handshake edge itself, so the
  // accepted element bypasses the hold registers; between handshakes the
  // unit sees the last element again while bubbles flow through.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      di_q     <= '0;
      muler_q  <= '0;
      rshift_q <= '0;
    end else if (hs) begin
      di_q     <= acc_data;
      muler_q  <= cfg_tbl[ch].muler;
      rshift_q <= cfg_tbl[ch].rshift;
    end
  end

  assign quant_di     = hs ? acc_data           : di_q;
  assign quant_muler  = hs ? cfg_tbl[ch].muler  : muler_q;
  assign quant_rshift = hs ? cfg_tbl[ch].rshift : rshift_q;

  al_accel_quant_pack u_pack (
    .clk       (clk),
    .resetn    (resetn),
    .clr       (start_ok),
    .in_valid  (consume),
    .in_data   (quant_do),
    .in_last   (last_elem),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .pending   (pk_pending)
  );

endmodule

// File: tb/tb_al_accel_quant_ctrl.sv
module tb_al_accel_quant_ctrl;

  localparam int LAT   = 3;
  localparam int CH_W  = 4;
  localparam int CNT_W = 16;
  localparam int NENT  = 2**CH_W;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             cfg_we = 1'b0;
  logic [CH_W-1:0]  cfg_addr = '0;
  logic [31:0]      cfg_muler = '0;
  logic [4:0]       cfg_rshift = '0;
  logic             start = 1'b0;
  logic [CH_W:0]    num_ch = '0;
  logic [CNT_W-1:0] len = '0;
  logic             busy, done;
  logic             acc_valid = 1'b0;
  logic             acc_ready;
  logic [31:0]      acc_data = '0;
  logic [31:0]      quant_di, quant_muler;
  logic [4:0]       quant_rshift;
  logic             quant_enb;
  logic [7:0]       quant_do;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_data;
  logic             out_last;

  always #5 clk = ~clk;

  al_accel_quant_ctrl #(.QUANT_LAT(LAT), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_muler(cfg_muler), .cfg_rshift(cfg_rshift),
    .start(start), .num_ch(num_ch), .len(len), .busy(busy), .done(done),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
    .quant_di(quant_di), .quant_muler(quant_muler), .quant_rshift(quant_rshift),
    .quant_enb(quant_enb), .quant_do(quant_do),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  // Pass-through quant unit: LAT enb-gated stages, result = di[7:0].
  logic [7:0] stub_pipe [LAT];
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < LAT; i++) stub_pipe[i] <= '0;
    end else if (quant_enb) begin
      stub_pipe[0] <= quant_di[7:0];
      for (int i = 1; i < LAT; i++) stub_pipe[i] <= stub_pipe[i-1];
    end
  end
  assign quant_do = stub_pipe[LAT-1];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model state
  typedef struct packed { logic [31:0] di; logic [31:0] m; logic [4:0] r; } beat_t;
  typedef struct packed { logic [31:0] w; logic l; } word_t;

  logic [31:0] sh_m [NENT];
  logic [4:0]  sh_r [NENT];
  logic [31:0] job_data [64];
  beat_t exp_beats[$];
  word_t exp_words[$];

  int          words_seen, done_seen, stall_cyc;
  logic [31:0] last_word_seen;
  bit          mon_en = 1'b0;
  int          rdy_pct = 100;
  int          hold_cnt = 0;

  // Element i uses channel i mod num_ch; word w holds elements 4w..4w+3,
  // zero-filled past the end, last flag on the final word.
  function automatic void build_model(input int n, input int nch);
    int eff;
    logic [31:0] w;
    eff = (nch == 0) ? 1 : nch;
    for (int i = 0; i < n; i++)
      exp_beats.push_back('{di: job_data[i], m: sh_m[i % eff], r: sh_r[i % eff]});
    for (int b = 0; b < n; b += 4) begin
      w = '0;
      for (int k = 0; k < 4; k++)
        if (b + k < n) w[8*k +: 8] = job_data[b+k][7:0];
      exp_words.push_back('{w: w, l: (b + 4 >= n)});
    end
  endfunction

  // Scoreboard, sampled on the falling edge where everything is settled.
  beat_t       mb;
  word_t       mw;
  bit          stall_prev = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;

  always @(negedge clk) begin
    if (mon_en && resetn) begin
      if (acc_valid && acc_ready) begin
        if (exp_beats.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_beat: got di %0h expected no element", quant_di);
        end else begin
          mb = exp_beats.pop_front();
          check("beat_di", quant_di, mb.di);
          check("beat_muler", quant_muler, mb.m);
          check("beat_rshift", quant_rshift, mb.r);
        end
      end
      if (out_valid && out_ready) begin
        words_seen++;
        last_word_seen = out_data;
        if (exp_words.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_word: got %0h expected no word", out_data);
        end else begin
          mw = exp_words.pop_front();
          check("word_data", out_data, mw.w);
          check("word_last", out_last, mw.l);
        end
      end
      if (stall_prev) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_data", out_data, prev_data);
        check("stall_hold_last", out_last, prev_last);
      end
      if (busy) begin
        if (out_valid && !out_ready) begin
          stall_cyc++;
          check("stall_enb", quant_enb, 0);
          check("stall_acc_ready", acc_ready, 0);
        end else begin
          check("free_enb", quant_enb, 1);
        end
      end
      if (done) begin
        done_seen++;
        check("done_busy", busy, 0);
        check("done_out_empty", out_valid, 0);
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Downstream ready: random at rdy_pct percent, or forced low while hold_cnt runs.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (hold_cnt > 0) begin
        out_ready = 1'b0;
        hold_cnt--;
      end else begin
        out_ready = ($urandom_range(99) < rdy_pct);
      end
    end
  end

  task automatic program_table();
    for (int i = 0; i < NENT; i++) begin
      @(posedge clk); #1;
      cfg_we = 1'b1; cfg_addr = CH_W'(i); cfg_muler = sh_m[i]; cfg_rshift = sh_r[i];
    end
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic fill_seq(input int n, input logic [7:0] base);
    logic [31:0] r;
    for (int i = 0; i < n; i++) begin
      r = $urandom();
      job_data[i] = {r[31:8], base + 8'(i)};
    end
  endtask

  task automatic run_job(input int n, input int nch, input int gap_pct, input int rp,
                         input int hold_at, input bit start_busy, input bit cfg_busy);
    int idx, cyc;
    bit hs;
    idx = 0; cyc = 0;
    words_seen = 0; done_seen = 0; stall_cyc = 0; last_word_seen = '0;
    rdy_pct = rp;
    build_model(n, nch);
    @(posedge clk); #1;
    start = 1'b1; len = CNT_W'(n); num_ch = (CH_W+1)'(nch);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    while (done_seen == 0 && cyc < 3000) begin
      if (idx < n) begin
        acc_valid = ($urandom_range(99) >= gap_pct);
        acc_data  = job_data[idx];
      end else begin
        acc_valid = 1'b0;
      end
      if (start_busy && cyc == 3) begin
        start = 1'b1; len = CNT_W'(3); num_ch = (CH_W+1)'(1);
      end else begin
        start = 1'b0;
      end
      if (cfg_busy && cyc == 4) begin
        cfg_we = 1'b1; cfg_addr = '0; cfg_muler = 32'hDEAD_BEEF; cfg_rshift = 5'd31;
      end else begin
        cfg_we = 1'b0;
      end
      if (cyc == hold_at) hold_cnt = 10;
      @(negedge clk);
      hs = acc_valid && acc_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      cyc++;
    end
    acc_valid = 1'b0; start = 1'b0; cfg_we = 1'b0;
    check("job_done_once", done_seen, 1);
    check("job_beats_left", exp_beats.size(), 0);
    check("job_words_left", exp_words.size(), 0);
  endtask

  typedef struct {
    int          n;
    int          nch;
    logic [7:0]  base;
    int          gap;
    int          rp;
    int          exp_nw;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int hs_cnt;
    vecs[0] = '{n: 6, nch: 3,  base: 8'h11, gap: 0,  rp: 100, exp_nw: 2, exp_last: 32'h0000_1615};
    vecs[1] = '{n: 4, nch: 1,  base: 8'h20, gap: 0,  rp: 100, exp_nw: 1, exp_last: 32'h2322_2120};
    vecs[2] = '{n: 1, nch: 0,  base: 8'hA0, gap: 0,  rp: 100, exp_nw: 1, exp_last: 32'h0000_00A0};
    vecs[3] = '{n: 9, nch: 16, base: 8'h30, gap: 30, rp: 50,  exp_nw: 3, exp_last: 32'h0000_0038};
    vecs[4] = '{n: 7, nch: 2,  base: 8'hF0, gap: 50, rp: 70,  exp_nw: 2, exp_last: 32'h00F6_F5F4};

    for (int i = 0; i < NENT; i++) begin
      sh_m[i] = $urandom();
      sh_r[i] = 5'($urandom_range(31));
    end
    sh_m[0] = 32'd1073742347;  sh_r[0] = 5'd10;
    sh_m[1] = 32'h4000_0000;   sh_r[1] = 5'd4;
    sh_m[2] = 32'h7FFF_FFFF;   sh_r[2] = 5'd0;

    // Reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_acc_ready", acc_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_enb", quant_enb, 0);
    check("rst_di", quant_di, 0);
    check("rst_muler", quant_muler, 0);
    check("rst_rshift", quant_rshift, 0);
    @(negedge clk);
    resetn = 1'b1;
    program_table();
    mon_en = 1'b1;

    // Table-driven jobs
    for (int v = 0; v < 5; v++) begin
      fill_seq(vecs[v].n, vecs[v].base);
      run_job(vecs[v].n, vecs[v].nch, vecs[v].gap, vecs[v].rp, -1, 1'b0, 1'b0);
      check("vec_nwords", words_seen, vecs[v].exp_nw);
      check("vec_last_word", last_word_seen, vecs[v].exp_last);
    end

    // len=0: straight to DONE, one done pulse, no output word
    @(posedge clk); #1;
    start = 1'b1; len = '0; num_ch = (CH_W+1)'(2);
    @(posedge clk); #1;
    start = 1'b0;
    check("len0_done", done, 1);
    check("len0_busy", busy, 0);
    check("len0_out_valid", out_valid, 0);
    @(posedge clk); #1;
    check("len0_done_drop", done, 0);
    check("len0_out_valid2", out_valid, 0);

    // Backpressure: 10 cycles of out_ready=0 in the middle of a long job
    fill_seq(16, 8'h40);
    run_job(16, 3, 0, 100, 12, 1'b0, 1'b0);
    check("bp_stall_seen", (stall_cyc >= 5), 1);
    check("bp_nwords", words_seen, 4);

    // start while busy is ignored (scoreboard still expects the full 12)
    fill_seq(12, 8'h60);
    run_job(12, 2, 10, 80, -1, 1'b1, 1'b0);
    check("sbusy_nwords", words_seen, 3);

    // Config write while busy is ignored; the next job keeps the old ch0
    fill_seq(8, 8'h70);
    run_job(8, 1, 0, 100, -1, 1'b0, 1'b1);
    fill_seq(5, 8'h80);
    run_job(5, 0, 20, 60, -1, 1'b0, 1'b0);

    // Randomized jobs against the model
    for (int j = 0; j < 6; j++) begin
      int n, nch;
      n   = $urandom_range(40, 1);
      nch = $urandom_range(16, 0);
      for (int i = 0; i < n; i++) job_data[i] = $urandom();
      run_job(n, nch, $urandom_range(60), $urandom_range(100, 30), -1, 1'b0, 1'b0);
      check("rand_nwords", words_seen, (n + 3) / 4);
    end

    // Reset in the middle of a job with two elements in flight
    rdy_pct = 100;
    fill_seq(8, 8'h90);
    mon_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; len = CNT_W'(8); num_ch = (CH_W+1)'(1);
    @(posedge clk); #1;
    start = 1'b0;
    hs_cnt = 0;
    for (int c = 0; c < 50 && hs_cnt < 2; c++) begin
      acc_valid = 1'b1; acc_data = job_data[hs_cnt];
      @(negedge clk);
      if (acc_valid && acc_ready) hs_cnt++;
      @(posedge clk); #1;
    end
    check("mid_rst_two_in", hs_cnt, 2);
    acc_valid = 1'b0;
    resetn = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_acc_ready", acc_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_last", out_last, 0);
    check("mid_rst_enb", quant_enb, 0);
    check("mid_rst_di", quant_di, 0);
    check("mid_rst_muler", quant_muler, 0);
    check("mid_rst_rshift", quant_rshift, 0);
    exp_beats.delete();
    exp_words.delete();
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    program_table();
    mon_en = 1'b1;
    fill_seq(5, 8'hC0);
    run_job(5, 2, 0, 100, -1, 1'b0, 1'b0);
    check("post_rst_nwords", words_seen, 2);
    check("post_rst_last", last_word_seen, 32'h0000_00C4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
